buffer_drain: RTL and testbench

- Downstream consumer stage for the team's buffer block.
- Sequences the buffer's pop / is_done / pop_ack handshake and captures each popped word.
- Re-presents each captured word on a valid/ready stream (m_*) for the next pipeline stage.
- Applies backpressure to the buffer by holding pop_ack, and detects pops lost to a simultaneous push.

---
 rtl/buffer_drain.sv | 209 ++++++++++++++++++++
 tb/tb_buffer_drain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_drain.sv
// ---------------------------------------------------------------------------
// buffer_drain
//
// Purpose:
//   Consumer stage for the team's buffer block. It runs the buffer's
//   pop / is_done / pop_ack handshake, captures each popped word into a
//   single output register slot and presents that word on a valid/ready
//   stream (m_*). While the output slot is occupied, buf_pop_ack stays high
//   so the buffer remains in DONE and keeps its data. If the buffer returns
//   to READY without ever reaching DONE, a simultaneous push took the pop.
//   In that case the word is not captured and the pop is issued again.
//
// Optional feature (macro BUFFER_DRAIN_TIMEOUT_EN):
//   When defined, WAIT gives up after TIMEOUT_CYCLES cycles without
//   buf_is_done. It then sets the sticky timeout_err and blocks new pops
//   until reset. When undefined, WAIT has no limit and timeout_err is 0.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst_n        in   synchronous reset, ACTIVE-HIGH despite the name
//   enable       in   1 = may start new pops
//   buf_pop      out  one-cycle pop request to the buffer
//   buf_pop_ack  out  held high while the buffer must stay in DONE
//   buf_data     in   buffer data_out
//   buf_is_ready in   buffer in READY
//   buf_is_done  in   buffer in DONE (data valid)
//   buf_is_empty in   buffer holds no data
//   m_data       out  output word
//   m_valid      out  output word valid
//   m_ready      in   downstream accepts
//   drain_count  out  words handed downstream (wraps)
//   busy         out  FSM not idle or output word pending
//   timeout_err  out  sticky WAIT timeout flag
// ---------------------------------------------------------------------------
module buffer_drain #(
    parameter int DATA_WIDTH     = 8,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   buf_pop,
    output logic                   buf_pop_ack,
    input  logic [DATA_WIDTH-1:0]  buf_data,
    input  logic                   buf_is_ready,
    input  logic                   buf_is_done,
    input  logic                   buf_is_empty,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] drain_count,
    output logic                   busy,
    output logic                   timeout_err
);

    // The counter is wide enough to hold TIMEOUT_CYCLES. It saturates
    // instead of wrapping, so a very long WAIT never aliases back to 0.
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CAPT = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic                   m_valid_reg, m_valid_next;
    logic [DATA_WIDTH-1:0]  m_data_reg, m_data_next;
    logic [COUNT_WIDTH-1:0] drain_count_reg, drain_count_next;

    logic out_free;
    logic capture;
    logic timeout_hit;
    logic pop_block;

    // The slot can take a new word if it is empty, or if it empties this cycle.
    assign out_free = !m_valid_reg || m_ready;

`ifdef BUFFER_DRAIN_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);

    logic timeout_err_reg, timeout_err_next;

    assign pop_block        = timeout_err_reg;
    assign timeout_err_next = timeout_err_reg | timeout_hit;
    assign timeout_err      = timeout_err_reg;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= timeout_err_next;
        end
    end
`else
    assign pop_block   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg       <= ST_IDLE;
            wait_cnt_reg    <= '0;
            m_valid_reg     <= 1'b0;
            m_data_reg      <= '0;
            drain_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            m_valid_reg     <= m_valid_next;
            m_data_reg      <= m_data_next;
            drain_count_reg <= drain_count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        capture       = 1'b0;
        timeout_hit   = 1'b0;
        buf_pop       = 1'b0;
        buf_pop_ack   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enable && !pop_block && buf_is_ready && !buf_is_empty && out_free) begin
                    state_next = ST_REQ;
                end
            end

            ST_REQ: begin
                buf_pop       = 1'b1;
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
            end

            ST_WAIT: begin
                buf_pop_ack = 1'b1;
                if (wait_cnt_reg != WAIT_MAX) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
                if (buf_is_done) begin
                    // If the slot is still occupied, stay here. The buffer
                    // then holds DONE and its data until the slot frees up.
                    if (out_free) begin
                        capture    = 1'b1;
                        state_next = ST_CAPT;
                    end
                end else if (buf_is_ready && (wait_cnt_reg != '0)) begin
                    // The buffer went back to READY without reaching DONE,
                    // so a concurrent push took the pop. Arbitrate again
                    // from IDLE.
                    state_next = ST_IDLE;
                end
`ifdef BUFFER_DRAIN_TIMEOUT_EN
                else if (wait_cnt_reg >= TIMEOUT_LIM) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
`endif
            end

            ST_CAPT: begin
                // Dropping pop_ack for this cycle releases the buffer to READY.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register slot
    // -----------------------------------------------------------------------
    always_comb begin
        m_valid_next     = m_valid_reg;
        m_data_next      = m_data_reg;
        drain_count_next = drain_count_reg;

        if (m_valid_reg && m_ready) begin
            drain_count_next = drain_count_reg + 1'b1;
            m_valid_next     = 1'b0;
        end
        // capture only happens when out_free, so a refill never overwrites
        // a word that has not transferred.
        if (capture) begin
            m_valid_next = 1'b1;
            m_data_next  = buf_data;
        end
    end

    assign m_valid     = m_valid_reg;
    assign m_data      = m_data_reg;
    assign drain_count = drain_count_reg;
    assign busy        = (state_reg != ST_IDLE) || m_valid_reg;

endmodule

// File: tb/tb_buffer_drain.sv
// ---------------------------------------------------------------------------
// tb_buffer_drain
//
// Self-checking bench for buffer_drain. A behavioural model of the team's
// buffer (READY -> POP -> DONE -> READY) supplies words. Each word loaded
// into the model is also pushed onto an expected-word queue. A monitor
// process pops that queue and compares whenever the DUT transfers a word
// on the m_* stream. Directed checks cover reset, backpressure, the empty
// buffer, push/pop collision, reset during WAIT, and WAIT timeout
// behaviour.
// ---------------------------------------------------------------------------
module tb_buffer_drain;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          buf_pop;
    logic          buf_pop_ack;
    logic [DW-1:0] buf_data;
    logic          buf_is_ready;
    logic          buf_is_done;
    logic          buf_is_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] drain_count;
    logic          busy;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;
    int pop_count = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] bq[$];

    // Buffer model state
    typedef enum logic [1:0] {B_READY, B_POP, B_DONE} bstate_t;
    bstate_t bstate;
    int      collide_req = 0;
    int      collide_ack = 0;
    logic    stall = 1'b0;

    buffer_drain #(
        .DATA_WIDTH(DW),
        .COUNT_WIDTH(CW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .buf_pop(buf_pop),
        .buf_pop_ack(buf_pop_ack),
        .buf_data(buf_data),
        .buf_is_ready(buf_is_ready),
        .buf_is_done(buf_is_done),
        .buf_is_empty(buf_is_empty),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .drain_count(drain_count),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // ---------------- buffer model ----------------
    assign buf_is_ready = (bstate == B_READY);
    assign buf_is_done  = (bstate == B_DONE);

    always @(posedge clk) begin
        if (rst_n) begin
            bstate <= B_READY;
        end else begin
            case (bstate)
                B_READY: if (buf_pop) bstate <= B_POP;
                B_POP: begin
                    if (stall) begin
                        bstate <= B_POP;
                    end else if (collide_req != collide_ack) begin
                        collide_ack <= collide_ack + 1;
                        bstate <= B_READY;
                    end else if (bq.size() == 0) begin
                        failures++;
                        $display("FAIL pop_from_empty: got pop expected none");
                        bstate <= B_READY;
                    end else begin
                        buf_data <= bq.pop_front();
                        bstate <= B_DONE;
                    end
                end
                B_DONE: if (!buf_pop_ack) bstate <= B_READY;
                default: bstate <= B_READY;
            endcase
        end
    end

    always @(negedge clk) buf_is_empty = (bq.size() == 0);

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            if (buf_pop) pop_count++;
            if (buf_pop && buf_pop_ack) begin
                checks++;
                failures++;
                $display("FAIL pop_and_ack_overlap: got 1 expected 0");
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
                end else begin
                    check("m_data_transfer", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic load(input logic [DW-1:0] w, input bit expect_out);
        bq.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (buf_pop_ack) begin
                seen = 1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        bq.delete();
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int p0;
        bit seen;
        rst_n   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        buf_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_buf_pop", 32'(buf_pop), 0);
        check("rst_buf_pop_ack", 32'(buf_pop_ack), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_drain_count", 32'(drain_count), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b0;

        // Test 1: two words in order
        m_ready = 1'b1;
        enable  = 1'b1;
        p0 = pop_count;
        load(8'hA5, 1);
        load(8'h3C, 1);
        wait_drain("t1_drained");
        check("t1_drain_count", 32'(drain_count), 2);
        check("t1_pops", 32'(pop_count - p0), 2);

        // Test 2: empty buffer, no pops
        p0 = pop_count;
        repeat (20) @(negedge clk);
        check("t2_pops", 32'(pop_count - p0), 0);
        check("t2_busy", 32'(busy), 0);

        // Test 3: backpressure on the first word
        m_ready = 1'b0;
        p0 = pop_count;
        load(8'h11, 1);
        load(8'h22, 1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1;
                break;
            end
        end
        check("t3_valid_seen", 32'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(m_valid), 1);
            check("t3_hold_data", 32'(m_data), 32'h11);
        end
        check("t3_single_pop", 32'(pop_count - p0), 1);
        m_ready = 1'b1;
        wait_drain("t3_drained");
        check("t3_pops", 32'(pop_count - p0), 2);
        check("t3_drain_count", 32'(drain_count), 4);

        // Test 4: pop lost to a push, must re-pop once
        p0 = pop_count;
        collide_req = collide_req + 1;
        load(8'h77, 1);
        wait_drain("t4_drained");
        check("t4_pops", 32'(pop_count - p0), 2);
        check("t4_drain_count", 32'(drain_count), 5);

        // Test 5: reset during WAIT
        load(8'h55, 0);
        wait_ack("t5_in_wait");
        do_reset();
        check("t5_buf_pop", 32'(buf_pop), 0);
        check("t5_buf_pop_ack", 32'(buf_pop_ack), 0);
        check("t5_m_valid", 32'(m_valid), 0);
        check("t5_m_data", 32'(m_data), 0);
        check("t5_drain_count", 32'(drain_count), 0);
        check("t5_busy", 32'(busy), 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Test 6: WAIT never sees DONE
        stall = 1'b1;
        load(8'h66, 0);
        wait_ack("t6_in_wait");
`ifdef BUFFER_DRAIN_TIMEOUT_EN
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                seen = 1;
                break;
            end
        end
        check("t6_timeout_err", 32'(seen), 1);
        check("t6_ack_dropped", 32'(buf_pop_ack), 0);
        // Return the model to READY with data still held; the DUT must not pop.
        collide_req = collide_req + 1;
        stall = 1'b0;
        p0 = pop_count;
        repeat (20) @(negedge clk);
        check("t6_no_pops", 32'(pop_count - p0), 0);
        check("t6_err_sticky", 32'(timeout_err), 1);
`else
        repeat (40) @(negedge clk);
        check("t6_still_wait", 32'(buf_pop_ack), 1);
        check("t6_timeout_err", 32'(timeout_err), 0);
        check("t6_busy", 32'(busy), 1);
`endif
        stall = 1'b0;
        do_reset();
        check("t6_reset_timeout_err", 32'(timeout_err), 0);
        rst_n = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
